multicycle_ctrl: RTL and testbench

- Multi-cycle control unit for the 8-bit CPU datapath: register file (16x8, r0 reads zero), PC register, 10-bit PC adder, 2:1 muxes, zero-flag flip-flop.
- Fetches 16-bit instructions from the instruction ROM over a req/ack handshake and holds them in an internal IR.
- Drives register addresses, the immediate, the jump target and every datapath enable/select, one FSM step per clock.

---
 rtl/multicycle_ctrl.sv | 151 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle control unit for the 8-bit CPU datapath
//
// Purpose: fetches 16-bit instructions from the instruction ROM over a
// rom_req/rom_ack handshake into an internal IR, then steps the datapath
// through DECODE / EXEC / WB, one FSM step per clock.
//
// Ports:
//   clk, reset         clock (rising edge), asynchronous active-high reset
//   start              IDLE -> FETCH trigger
//   instr, rom_ack     ROM data and its data-valid strobe
//   zero               zero flag from the datapath flip-flop
//   rom_req            instruction fetch request
//   ra1, ra2, wa3      register file addresses (from IR)
//   imm, jaddr, alu_op immediate, jump target, ALU operation (from IR)
//   we3, s_imm         register write enable, write-data select (1 = imm)
//   pc_en, s_jmp       PC load enable, PC select (1 = jaddr)
//   z_load             zero-flag load enable
//   halted, fault      HALT / FAULT status

module multicycle_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int PC_W     = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [15:0]     instr,
  input  logic            rom_ack,
  input  logic            zero,
  output logic            rom_req,
  output logic [3:0]      ra1,
  output logic [3:0]      ra2,
  output logic [3:0]      wa3,
  output logic [7:0]      imm,
  output logic [PC_W-1:0] jaddr,
  output logic [2:0]      alu_op,
  output logic            we3,
  output logic            s_imm,
  output logic            pc_en,
  output logic            s_jmp,
  output logic            z_load,
  output logic            halted,
  output logic            fault
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  // Last FETCH cycle (counted from 0) in which an ack is still accepted.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [15:0] ir;
  logic [7:0]  wait_cnt;

  logic [3:0] opc;
  logic       is_alu;
  logic       is_loadi;
  logic       is_j;
  logic       is_jz;
  logic       is_jnz;
  logic       is_halt;
  logic       is_nop;
  logic       is_branch;

  assign opc       = ir[15:12];
  assign is_alu    = ~ir[15];
  assign is_loadi  = (opc == 4'b1000);
  assign is_j      = (opc == 4'b1001);
  assign is_jz     = (opc == 4'b1010);
  assign is_jnz    = (opc == 4'b1011);
  assign is_halt   = (opc == 4'b1110);
  assign is_nop    = (opc == 4'b1111);
  // Instructions that finish in DECODE by loading the PC.
  assign is_branch = is_j | is_jz | is_jnz | is_nop;

  // Instruction fields are always visible, whatever the state.
  assign ra1    = ir[11:8];
  assign ra2    = ir[7:4];
  assign wa3    = ir[3:0];
  assign imm    = ir[11:4];
  assign jaddr  = PC_W'(ir[9:0]);
  assign alu_op = ir[14:12];

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (rom_ack)                     state_nxt = S_DECODE;
        else if (wait_cnt == WAIT_LAST)  state_nxt = S_FAULT;
      end
      S_DECODE: begin
        if (is_alu)         state_nxt = S_EXEC;
        else if (is_loadi)  state_nxt = S_WB;
        else if (is_branch) state_nxt = S_FETCH;
        else if (is_halt)   state_nxt = S_HALT;
        else                state_nxt = S_FAULT;
      end
      S_EXEC:  state_nxt = S_WB;
      S_WB:    state_nxt = S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      ir       <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && rom_ack) begin
        ir <= instr;
      end
      // Counter only runs while waiting in FETCH; any other state
      // holds it at zero so every FETCH entry starts from a clean count.
      if (state == S_FETCH && !rom_ack) begin
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // Strobes are decoded from state (and IR/zero in DECODE), so an
  // asynchronous reset drops them in the same cycle it is asserted.
  always_comb begin
    rom_req = (state == S_FETCH);
    z_load  = (state == S_EXEC);
    we3     = (state == S_WB) && (wa3 != 4'd0);
    s_imm   = (state == S_WB) && is_loadi;
    pc_en   = (state == S_WB) || ((state == S_DECODE) && is_branch);
    s_jmp   = (state == S_DECODE) &&
              (is_j || (is_jz && zero) || (is_jnz && !zero));
    halted  = (state == S_HALT);
    fault   = (state == S_FAULT);
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl

module tb_multicycle_ctrl;

  localparam int WAIT_MAX = 15;
  localparam int PC_W     = 10;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [15:0]     instr;
  logic            rom_ack;
  logic            zero;
  logic            rom_req;
  logic [3:0]      ra1, ra2, wa3;
  logic [7:0]      imm;
  logic [PC_W-1:0] jaddr;
  logic [2:0]      alu_op;
  logic            we3, s_imm, pc_en, s_jmp, z_load, halted, fault;

  multicycle_ctrl #(.WAIT_MAX(WAIT_MAX), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr),
    .rom_ack(rom_ack), .zero(zero), .rom_req(rom_req),
    .ra1(ra1), .ra2(ra2), .wa3(wa3), .imm(imm), .jaddr(jaddr),
    .alu_op(alu_op), .we3(we3), .s_imm(s_imm), .pc_en(pc_en),
    .s_jmp(s_jmp), .z_load(z_load), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  // Strobe vector bit order: rom_req we3 s_imm pc_en s_jmp z_load halted fault
  localparam logic [7:0] ST_FETCH  = 8'h80;
  localparam logic [7:0] ST_ZLOAD  = 8'h04;
  localparam logic [7:0] ST_HALTED = 8'h02;
  localparam logic [7:0] ST_FAULT  = 8'h01;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        exp_valid = 1'b0;
  logic [7:0]  exp_strb  = 8'h00;
  logic [15:0] m_ir      = 16'h0000;

  // Compare process: every cycle, strobes against the expectation and
  // fields against the instruction the model says sits in the IR.
  always @(negedge clk) begin
    if (exp_valid) begin
      logic [7:0]  got_s;
      logic [32:0] got_f, exp_f;
      got_s = {rom_req, we3, s_imm, pc_en, s_jmp, z_load, halted, fault};
      got_f = {ra1, ra2, wa3, imm, jaddr, alu_op};
      exp_f = {m_ir[11:8], m_ir[7:4], m_ir[3:0], m_ir[11:4], m_ir[9:0], m_ir[14:12]};
      n_checks++;
      if (got_s !== exp_strb) begin
        n_fail++;
        $display("FAIL strobes t=%0t got %b expected %b", $time, got_s, exp_strb);
      end
      n_checks++;
      if (got_f !== exp_f) begin
        n_fail++;
        $display("FAIL fields t=%0t got %h expected %h", $time, got_f, exp_f);
      end
    end
  end

  task automatic pin(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  // Declare the expected strobes for the current cycle, advance to next.
  task automatic step(input logic [7:0] strb);
    exp_strb  = strb;
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_now();
    reset    = 1'b1;
    start    = 1'b0;
    rom_ack  = 1'($urandom);
    m_ir     = 16'h0000;
    exp_strb = 8'h00;
    #1;
    pin("reset_strobes", 32'({rom_req, we3, s_imm, pc_en, s_jmp, z_load, halted, fault}), 32'h0);
    pin("reset_fields", 32'({ra1, ra2, wa3, imm, alu_op}) | 32'(jaddr), 32'h0);
    step(8'h00);
    reset = 1'b0;
    repeat (3) begin
      rom_ack = 1'($urandom);
      instr   = 16'($urandom);
      step(8'h00);
    end
  endtask

  task automatic start_run();
    start   = 1'b1;
    rom_ack = 1'($urandom);
    step(8'h00);
  endtask

  // Runs one instruction: FETCH with `dly` ack-less cycles, then the
  // per-class cycle sequence. status: 0 back in FETCH, 1 halted, 2 fault.
  task automatic run_instr(input logic [15:0] ins, input int dly, input logic z,
                           output int status);
    logic we;
    zero   = z;
    status = 0;
    for (int k = 0; k <= dly && k < WAIT_MAX; k++) begin
      start   = 1'($urandom);
      rom_ack = (k == dly);
      instr   = (k == dly) ? ins : 16'($urandom);
      step(ST_FETCH);
    end
    if (dly >= WAIT_MAX) begin
      status = 2;
      return;
    end
    m_ir    = ins;
    rom_ack = 1'($urandom);
    instr   = 16'($urandom);
    we      = (ins[3:0] != 4'd0);
    if (!ins[15]) begin
      step(8'h00);
      step(ST_ZLOAD);
      step({1'b0, we, 1'b0, 1'b1, 4'b0});
    end else begin
      case (ins[15:12])
        4'h8: begin
          step(8'h00);
          step({1'b0, we, 1'b1, 1'b1, 4'b0});
        end
        4'h9: step(8'h18);
        4'hA: step({3'b000, 1'b1, z, 3'b000});
        4'hB: step({3'b000, 1'b1, ~z, 3'b000});
        4'hF: step(8'h10);
        4'hE: begin step(8'h00); status = 1; end
        default: begin step(8'h00); status = 2; end
      endcase
    end
  endtask

  task automatic terminal(input int st, input int n);
    repeat (n) begin
      start   = 1'($urandom);
      rom_ack = 1'($urandom);
      instr   = 16'($urandom);
      zero    = 1'($urandom);
      step(st == 1 ? ST_HALTED : ST_FAULT);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    reset = 1'b1; start = 1'b0; rom_ack = 1'b0; instr = 16'h0; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_now();

    // ALU r1,r2 -> r3, ack in the first FETCH cycle
    start_run();
    run_instr(16'h0123, 0, 1'b0, st);
    pin("alu_ra1", 32'(ra1), 32'h1);
    pin("alu_ra2", 32'(ra2), 32'h2);
    pin("alu_wa3", 32'(wa3), 32'h3);
    pin("alu_op", 32'(alu_op), 32'h0);

    // LOADI to r0 (no write) and to r5
    run_instr(16'h8A50, 0, 1'b0, st);
    run_instr(16'h8A55, 2, 1'b1, st);
    pin("loadi_imm", 32'(imm), 32'hA5);
    pin("loadi_wa3", 32'(wa3), 32'h5);

    // Conditional jumps, both flag values
    run_instr(16'hA07F, 0, 1'b1, st);
    pin("jz_jaddr", 32'(jaddr), 32'h07F);
    run_instr(16'hA07F, 1, 1'b0, st);
    run_instr(16'hB07F, 0, 1'b1, st);
    run_instr(16'hB07F, 0, 1'b0, st);
    run_instr(16'h9123, 0, 1'b0, st);
    run_instr(16'hF000, 0, 1'b0, st);

    // Longest accepted ROM wait, then a timeout
    run_instr(16'h7321, WAIT_MAX - 1, 1'b0, st);
    run_instr(16'h0000, WAIT_MAX, 1'b0, st);
    terminal(st, 20);
    pin("timeout_fault", 32'(fault), 32'h1);
    pin("timeout_rom_req", 32'(rom_req), 32'h0);

    // HALT and undefined opcode
    reset_now();
    start_run();
    run_instr(16'hE000, 0, 1'b0, st);
    terminal(st, 20);
    pin("halt_halted", 32'(halted), 32'h1);
    reset_now();
    start_run();
    run_instr(16'hC000, 0, 1'b0, st);
    terminal(st, 5);
    pin("undef_fault", 32'(fault), 32'h1);

    // Reset during EXEC
    reset_now();
    start_run();
    rom_ack = 1'b1; instr = 16'h0456;
    step(ST_FETCH);
    m_ir = 16'h0456; rom_ack = 1'b0;
    step(8'h00);
    reset_now();

    // Reset during a FETCH wait
    start_run();
    rom_ack = 1'b0;
    repeat (5) step(ST_FETCH);
    reset_now();

    // Randomized programs
    for (int run = 0; run < 8; run++) begin
      start_run();
      for (int i = 0; i < 40; i++) begin
        int r, dly;
        logic [15:0] ins;
        ins = 16'($urandom);
        r   = int'($urandom_range(0, 99));
        dly = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WAIT_MAX - 1))
                                         : int'($urandom_range(0, 2));
        if (r < 40)      ins[15]    = 1'b0;
        else if (r < 60) ins[15:12] = 4'h8;
        else if (r < 92) begin
          case ($urandom_range(0, 3))
            0: ins[15:12] = 4'h9;
            1: ins[15:12] = 4'hA;
            2: ins[15:12] = 4'hB;
            default: ins[15:12] = 4'hF;
          endcase
        end
        else if (r < 94) ins[15:12] = 4'hE;
        else if (r < 97) ins[15:12] = ($urandom_range(0, 1) == 0) ? 4'hC : 4'hD;
        else             dly = WAIT_MAX;
        run_instr(ins, dly, 1'($urandom), st);
        if (st != 0) begin
          terminal(st, 10);
          break;
        end
      end
      reset_now();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
